// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the CPU load/store port: word array with wait
// states, completion pulse, error flagging and a sticky memory-mapped halt register.
module data_mem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enables,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        access_error,
    output logic        halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {CLS_READ, CLS_WRITE, CLS_HALT, CLS_ERR} cls_t;

    state_t         state;
    cls_t           cls_q;
    cls_t           req_cls_c;
    cls_t           cur_cls_c;
    logic [AW-1:0]  idx_q;
    logic [AW-1:0]  req_idx_c;
    logic [AW-1:0]  cur_idx_c;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    off_c;
    logic           req_c;
    logic           enter_resp_c;
    logic [31:0]    mem [DEPTH];

    // Classify the live request; BASE_ADDR is word-aligned so off_c[1:0] == address[1:0].
    always_comb begin
        off_c     = address - BASE_ADDR;
        req_idx_c = off_c[AW+1:2];
        req_c     = read_enable | write_enable;
        if (read_enable && write_enable)
            req_cls_c = CLS_ERR;
        else if (off_c[1:0] != 2'b00)
            req_cls_c = CLS_ERR;
        else if (write_enable && (address == HALT_ADDR))
            req_cls_c = CLS_HALT;
        else if (read_enable && (address == HALT_ADDR))
            req_cls_c = CLS_ERR;
        else if (|off_c[31:AW+2])
            req_cls_c = CLS_ERR;
        else if (read_enable)
            req_cls_c = CLS_READ;
        else
            req_cls_c = CLS_WRITE;
    end

    // With zero wait states RESP is entered straight from IDLE using the live request.
    always_comb begin
        cur_cls_c    = (state == IDLE) ? req_cls_c : cls_q;
        cur_idx_c    = (state == IDLE) ? req_idx_c : idx_q;
        enter_resp_c = ((state == IDLE) && req_c && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && (cnt_q == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cls_q        <= CLS_ERR;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            cnt_q        <= '0;
            read_data    <= '0;
            mem_ready    <= 1'b0;
            access_error <= 1'b0;
            halted       <= 1'b0;
        end else begin
            mem_ready    <= 1'b0;
            access_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c) begin
                        cls_q   <= req_cls_c;
                        idx_q   <= req_idx_c;
                        wdata_q <= write_data;
                        be_q    <= byte_enables;
                        if (WAIT_STATES != 0) begin
                            state <= WAIT;
                            cnt_q <= CW'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CW'(1);
                end
                RESP: begin
                    state <= IDLE;
                    if ((cls_q == CLS_HALT) && (be_q != 4'h0))
                        halted <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp_c) begin
                state        <= RESP;
                mem_ready    <= 1'b1;
                access_error <= (cur_cls_c == CLS_ERR);
                if (cur_cls_c == CLS_ERR)
                    read_data <= '0;
                else if (cur_cls_c == CLS_READ)
                    read_data <= mem[cur_idx_c];
            end
        end
    end

    // Byte-lane store during RESP; an async reset forces IDLE so an aborted access never writes.
    always_ff @(posedge clk) begin
        if ((state == RESP) && (cls_q == CLS_WRITE)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i])
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: two instances (0 and 1 wait states), directed
// and randomized accesses predicted by a behavioural word-array model.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] HALT  = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr [2];
    logic        re   [2];
    logic        we   [2];
    logic [31:0] wd   [2];
    logic [3:0]  ben  [2];
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, err0, err1, halt0, halt1;
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        errv  [2];
    logic        hlt   [2];

    assign rdata[0] = rdata0;  assign rdata[1] = rdata1;
    assign rdy[0]   = ready0;  assign rdy[1]   = ready1;
    assign errv[0]  = err0;    assign errv[1]  = err1;
    assign hlt[0]   = halt0;   assign hlt[1]   = halt1;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];
    logic        exp_halt [2];
    exp_t        me;

    data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .HALT_ADDR(HALT)) u_dut0 (
        .clk(clk), .rst(rst), .address(addr[0]), .read_enable(re[0]), .write_enable(we[0]),
        .write_data(wd[0]), .byte_enables(ben[0]), .read_data(rdata0), .mem_ready(ready0),
        .access_error(err0), .halted(halt0));

    data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1), .HALT_ADDR(HALT)) u_dut1 (
        .clk(clk), .rst(rst), .address(addr[1]), .read_enable(re[1]), .write_enable(we[1]),
        .write_data(wd[1]), .byte_enables(ben[1]), .read_data(rdata1), .mem_ready(ready1),
        .access_error(err1), .halted(halt1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: classify by the access rules and update a plain word array.
    task automatic predict(input int d, input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] data, input logic [3:0] be, output exp_t e);
        logic [31:0] word_off;
        word_off = (a - BASE) / 4;
        e.err  = 1'b0;
        e.halt = 1'b0;
        if (r && w)                       e.err = 1'b1;
        else if (a % 4 != 0)              e.err = 1'b1;
        else if (w && a == HALT)          e.halt = (be != 4'h0);
        else if (r && a == HALT)          e.err = 1'b1;
        else if (word_off >= 32'(DEPTH))  e.err = 1'b1;
        else if (r)                       last_rd[d] = mdl[d][int'(word_off)];
        else begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[d][int'(word_off)][8*i +: 8] = data[8*i +: 8];
        end
        if (e.err) last_rd[d] = 32'h0;
        e.rd = last_rd[d];
    endtask

    // Issue one request, hold it until mem_ready, drop it the following cycle.
    task automatic access(input int d, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] data, input logic [3:0] be, output int done_cyc);
        exp_t e;
        int   n;
        predict(d, a, r, w, data, be, e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        addr[d] = a; re[d] = r; we[d] = w; wd[d] = data; ben[d] = be;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy[d] && n < 40);
        if (!rdy[d]) begin
            n_total++;
            $display("FAIL timeout dut%0d addr %h: no mem_ready after %0d cycles", d, a, n);
        end else begin
            check($sformatf("latency dut%0d", d), 32'(n), 32'(ws_of(d) + 1));
        end
        done_cyc = cyc;
        @(posedge clk); #1;
        re[d] = 1'b0; we[d] = 1'b0;
    endtask

    // Monitor: compare every completion against the scoreboard, and idle outputs otherwise.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("halted dut%0d", d), 32'(hlt[d]), 32'(exp_halt[d]));
                if (rdy[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_total++;
                        $display("FAIL unexpected mem_ready dut%0d: got 1 expected 0", d);
                    end else begin
                        if (d == 0) me = q0.pop_front(); else me = q1.pop_front();
                        check($sformatf("read_data dut%0d", d), rdata[d], me.rd);
                        check($sformatf("access_error dut%0d", d), 32'(errv[d]), 32'(me.err));
                        if (me.halt) exp_halt[d] = 1'b1;
                    end
                end else begin
                    check($sformatf("access_error idle dut%0d", d), 32'(errv[d]), 32'h0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_total++;
        $display("FAIL watchdog: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        int t, t_prev, k, wi;
        logic r;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; re[d] = 1'b0; we[d] = 1'b0; wd[d] = '0; ben[d] = '0;
            last_rd[d] = '0; exp_halt[d] = 1'b0;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset read_data dut%0d", d), rdata[d], 32'h0);
            check($sformatf("reset mem_ready dut%0d", d), 32'(rdy[d]), 32'h0);
            check($sformatf("reset access_error dut%0d", d), 32'(errv[d]), 32'h0);
            check($sformatf("reset halted dut%0d", d), 32'(hlt[d]), 32'h0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known contents for the words exercised below.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                access(d, 32'(w * 4), 1'b0, 1'b1, $urandom, 4'hF, t);

        // One wait state: full store, partial store, errors, halt.
        access(1, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, t);
        access(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(1, 32'h10, 1'b0, 1'b1, 32'h11223344, 4'b0101, t);
        access(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(1, 32'h12, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(1, 32'h1000, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(1, 32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF, t);
        access(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(0, HALT, 1'b0, 1'b1, 32'h1, 4'h0, t);
        access(1, HALT, 1'b0, 1'b1, 32'h1, 4'h1, t);
        access(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, t);
        access(1, HALT, 1'b1, 1'b0, 32'h0, 4'h0, t);

        // Zero wait states: back-to-back loads complete every two cycles.
        access(0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, t_prev);
        access(0, 32'h4, 1'b1, 1'b0, 32'h0, 4'h0, t);
        check("b2b spacing 1", 32'(t - t_prev), 32'h2);
        t_prev = t;
        access(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'h0, t);
        check("b2b spacing 2", 32'(t - t_prev), 32'h2);

        // Randomized mix on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                k  = $urandom_range(0, 9);
                wi = $urandom_range(0, 15);
                a  = 32'(wi * 4);
                r  = 1'($urandom_range(0, 1));
                if (k <= 3)      access(d, a, 1'b0, 1'b1, $urandom, 4'($urandom), t);
                else if (k <= 6) access(d, a, 1'b1, 1'b0, $urandom, 4'($urandom), t);
                else if (k == 7) access(d, a + 32'($urandom_range(1, 3)), r, !r, $urandom, 4'hF, t);
                else if (k == 8) access(d, 32'h1000 + ($urandom & 32'h7FFF_FFF0), r, !r, $urandom, 4'hF, t);
                else begin
                    case ($urandom_range(0, 2))
                        0:       access(d, a, 1'b1, 1'b1, $urandom, 4'hF, t);
                        1:       access(d, HALT, 1'b1, 1'b0, 32'h0, 4'h0, t);
                        default: access(d, HALT, 1'b0, 1'b1, $urandom, 4'($urandom), t);
                    endcase
                end
            end
        end

        // Reset during WAIT of a store aborts it.
        access(1, 32'h20, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, t);
        addr[1] = 32'h20; we[1] = 1'b1; wd[1] = 32'h0BADF00D; ben[1] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_halt[d] = 1'b0;
            last_rd[d]  = 32'h0;
        end
        #1;
        check("abort read_data", rdata1, 32'h0);
        check("abort mem_ready", 32'(ready1), 32'h0);
        check("abort access_error", 32'(err1), 32'h0);
        check("abort halted", 32'(halt1), 32'h0);
        we[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        access(1, 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, t);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard drained dut0", 32'(q0.size()), 32'h0);
        check("scoreboard drained dut1", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller directly downstream of the CPU load/store port. It consumes address, read_enable, write_enable, write_data and byte_enables, and returns read_data.
- Backing store is an internal word array with a configurable number of wait states.
- A mem_ready completion handshake stalls the CPU until the access finishes.
- A memory-mapped halt register drives the CPU halted flag.
- Misaligned, out-of-range or conflicting requests are flagged with access_error instead of corrupting memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two, >=4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned).
- WAIT_STATES, 1, extra cycles between accept and completion (0..15).
- HALT_ADDR, 32'hFFFF_FFF0, byte address of the write-only halt register (outside the array range).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- address  in  32  byte address of request.
- read_enable  in  1  load request.
- write_enable  in  1  store request.
- write_data  in  32  store data, lane i = bits [8i+7:8i].
- byte_enables  in  4  store lane enables; ignored for loads.
- read_data  out  32  load result.
- mem_ready  out  1  one-cycle completion pulse.
- access_error  out  1  valid with mem_ready; request was illegal.
- halted  out  1  sticky, set by write to HALT_ADDR.

Behaviour:
- Reset (rst=0, async): state=IDLE; read_data=0, mem_ready=0, access_error=0, halted=0, wait counter=0. Array contents are not cleared. Reset asserted mid-access aborts it with no array write and no mem_ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if read_enable|write_enable, latch address/write_data/byte_enables/op and classify. Next state is WAIT if WAIT_STATES>0, else RESP. Otherwise stay in IDLE.
  - WAIT: counter counts from WAIT_STATES-1 down to 0; go to RESP when it reaches 0.
  - RESP: mem_ready=1 for exactly this cycle; next state is IDLE.
- Latency: request accepted at edge T -> mem_ready high in cycle T+WAIT_STATES+1.
- Requester holds the request until it sees mem_ready and must change or drop it in the following cycle. A request present in IDLE is always treated as new.
- Classification, first match wins:
  - read_enable & write_enable -> error.
  - address[1:0]!=0 -> error.
  - write to HALT_ADDR -> halt.
  - read of HALT_ADDR -> error.
  - (address-BASE_ADDR)>>2 >= DEPTH, unsigned, including address<BASE_ADDR wrap -> error.
  - otherwise -> normal.
- Error access: no array write, halted unchanged, read_data=0, access_error=1 during RESP.
- Normal store: in RESP cycle, write each lane i with byte_enables[i]=1; other lanes keep their value. byte_enables=0 completes with no change. read_data unchanged.
- Normal load: read_data = full word, loaded at entry to RESP and held until the next load or error completes. Stores do not alter it.
- Halt write: halted=1 from the cycle after RESP, sticky until reset. Requires any byte_enables bit set; be=0 is a no-op. No array write. access_error=0.
- After halted, requests are still serviced normally.
- access_error=0 outside RESP.

Test Plan:
- WAIT_STATES=1: store 0xDEADBEEF, be=4'hF, to 0x10; then load 0x10 -> mem_ready 2 cycles after each accept, read_data=0xDEADBEEF, access_error=0.
- Store 0x11223344, be=4'b0101, over 0xDEADBEEF at 0x10, then load -> read_data=0xDE22BE44.
- Load 0x12 (misaligned), then load 0x1000 with DEPTH=1024 (out of range) -> each gives mem_ready with access_error=1, read_data=0, array untouched. Read and write both high -> error.
- Store be=4'h1 to 0xFFFFFFF0 -> halted=1 the cycle after mem_ready, stays 1. Later load 0x10 still returns the stored data. Read of 0xFFFFFFF0 -> error.
- WAIT_STATES=0: back-to-back loads of 0x0,0x4,0x8 with request changed the cycle after each mem_ready -> mem_ready every 2 cycles, correct data each time.
- Assert rst during WAIT of a store to 0x20 -> no mem_ready, outputs 0. After release, load 0x20 -> prior contents unchanged.
